timer_set_ctrl: RTL and testbench

- Sequences the timer's hour/minute/second counter chain.
- Generates the 1 Hz count enable that drives the chain during normal running.
- Runs a button-driven edit FSM (hours, then minutes) and loads the edited values into the hour and minute counters over one shared BCD set bus, using single-cycle load strobes.
- Sits between the debounced button logic and the counter chain; the counters themselves are unchanged.

---
 rtl/timer_set_ctrl_if.sv | 31 +++
 rtl/timer_set_ctrl.sv | 156 +++++++++++++++
 tb/tb_timer_set_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_set_ctrl_if.sv
// Bundle between the debounced buttons, the counter chain and the timer set controller.
// The controller uses the slave modport; the button/counter side uses master.
interface timer_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_cancel;
    logic [7:0] cur_hr;
    logic [7:0] cur_min;
    logic       tick;
    logic       set_hr;
    logic       set_min;
    logic       sec_clr;
    logic [3:0] set_num1;
    logic [3:0] set_num2;
    logic [7:0] edit_hr;
    logic [7:0] edit_min;
    logic       blink;
    logic       editing;

    modport master (
        output btn_mode, btn_inc, btn_cancel, cur_hr, cur_min,
        input  tick, set_hr, set_min, sec_clr, set_num1, set_num2,
               edit_hr, edit_min, blink, editing
    );

    modport slave (
        input  btn_mode, btn_inc, btn_cancel, cur_hr, cur_min,
        output tick, set_hr, set_min, sec_clr, set_num1, set_num2,
               edit_hr, edit_min, blink, editing
    );
endinterface

// File: rtl/timer_set_ctrl.sv
// Timer set controller: 1 Hz tick prescaler, hour/minute edit FSM and
// strobed loading of the edited values into the counter chain over a shared BCD bus.
module timer_set_ctrl #(
    parameter int CLK_DIV   = 50000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    timer_set_ctrl_if.slave  bus
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {RUN, EDIT_HR, EDIT_MIN, LOAD_HR, LOAD_MIN} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            tick_q, tick_d;
    logic            set_hr_q, set_hr_d;
    logic            set_min_q, set_min_d;
    logic            sec_clr_q, sec_clr_d;
    logic [7:0]      set_num_q, set_num_d;
    logic [7:0]      edit_hr_q, edit_hr_d;
    logic [7:0]      edit_min_q, edit_min_d;
    logic            blink_q, blink_d;
    logic            editing_q, editing_d;
    logic            count_en;

    // BCD increment that wraps to 00 once the field's maximum is reached.
    function automatic logic [7:0] bcdInc(input logic [7:0] v, input logic [7:0] maxV);
        if (v == maxV)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            tick_q      <= 1'b0;
            set_hr_q    <= 1'b0;
            set_min_q   <= 1'b0;
            sec_clr_q   <= 1'b0;
            set_num_q   <= 8'h00;
            edit_hr_q   <= 8'h00;
            edit_min_q  <= 8'h00;
            blink_q     <= 1'b0;
            editing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            tick_q      <= tick_d;
            set_hr_q    <= set_hr_d;
            set_min_q   <= set_min_d;
            sec_clr_q   <= sec_clr_d;
            set_num_q   <= set_num_d;
            edit_hr_q   <= edit_hr_d;
            edit_min_q  <= edit_min_d;
            blink_q     <= blink_d;
            editing_q   <= editing_d;
        end
    end

    // Cancel outranks mode, which outranks inc.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (bus.btn_mode) state_d = EDIT_HR;
            EDIT_HR:  if (bus.btn_cancel) state_d = RUN;
                      else if (bus.btn_mode) state_d = EDIT_MIN;
            EDIT_MIN: if (bus.btn_cancel) state_d = RUN;
                      else if (bus.btn_mode) state_d = LOAD_HR;
            LOAD_HR:  state_d = LOAD_MIN;
            LOAD_MIN: state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        presc_d     = presc_q;
        blink_cnt_d = blink_cnt_q;
        tick_d      = 1'b0;
        set_hr_d    = 1'b0;
        set_min_d   = 1'b0;
        sec_clr_d   = 1'b0;
        set_num_d   = set_num_q;
        edit_hr_d   = edit_hr_q;
        edit_min_d  = edit_min_q;
        blink_d     = blink_q;
        editing_d   = (state_d == EDIT_HR) || (state_d == EDIT_MIN);

        // The prescaler only advances on cycles that stay in (or return to) RUN, so it is frozen across edits.
        count_en = ((state_q == RUN) || (state_q == LOAD_MIN)) && (state_d == RUN);
        if (state_q == LOAD_HR) begin
            presc_d = '0;
        end else if (count_en) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (state_q == RUN && bus.btn_mode) begin
            edit_hr_d  = bus.cur_hr;
            edit_min_d = bus.cur_min;
        end
        if (state_q == EDIT_HR && !bus.btn_cancel && !bus.btn_mode && bus.btn_inc)
            edit_hr_d = bcdInc(edit_hr_q, 8'h23);
        if (state_q == EDIT_MIN && !bus.btn_cancel && !bus.btn_mode && bus.btn_inc)
            edit_min_d = bcdInc(edit_min_q, 8'h59);

        if (state_d == LOAD_HR) begin
            set_hr_d  = 1'b1;
            set_num_d = edit_hr_q;
        end else if (state_d == LOAD_MIN) begin
            set_min_d = 1'b1;
            sec_clr_d = 1'b1;
            set_num_d = edit_min_q;
        end

        if (editing_d && editing_q) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.set_hr   = set_hr_q;
    assign bus.set_min  = set_min_q;
    assign bus.sec_clr  = sec_clr_q;
    assign bus.set_num1 = set_num_q[7:4];
    assign bus.set_num2 = set_num_q[3:0];
    assign bus.edit_hr  = edit_hr_q;
    assign bus.edit_min = edit_min_q;
    assign bus.blink    = blink_q;
    assign bus.editing  = editing_q;

endmodule

// File: tb/tb_timer_set_ctrl.sv
// Self-checking bench for timer_set_ctrl: a table-driven edit/load sequence, directed
// corner cases and randomized button traffic checked against a time/field-level model.
module tb_timer_set_ctrl;

    localparam int CLK_DIV   = 10;
    localparam int BLINK_DIV = 4;

    localparam int M_RUN  = 0;
    localparam int M_EHR  = 1;
    localparam int M_EMIN = 2;
    localparam int M_LHR  = 3;
    localparam int M_LMIN = 4;

    logic clk = 1'b0;
    logic rst;

    timer_set_ctrl_if bus ();

    timer_set_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vecCount = 0;
    int errCount = 0;

    int         mState;
    int         hrVal;
    int         minVal;
    int         runCount;
    int         editCycles;
    logic [7:0] expNum;
    logic       expTick;
    logic       expSetHr;
    logic       expSetMin;
    logic       expBlink;
    logic       expEditing;

    typedef struct {
        logic       mode;
        logic       inc;
        logic       cancel;
        logic [7:0] editHr;
        logic [7:0] editMin;
        logic       editing;
        logic       setHr;
        logic       setMin;
        logic [7:0] num;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [7:0] toBcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    function automatic int fromBcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mState     = M_RUN;
        hrVal      = 0;
        minVal     = 0;
        runCount   = 0;
        editCycles = 0;
        expNum     = 8'h00;
        expTick    = 1'b0;
        expSetHr   = 1'b0;
        expSetMin  = 1'b0;
        expBlink   = 1'b0;
        expEditing = 1'b0;
    endtask

    // One clock edge of the timer as seen from outside: whole hours/minutes, elapsed run time and edit time.
    task automatic modelStep();
        int nxt;
        logic wasEdit;
        logic isEdit;
        nxt       = mState;
        expTick   = 1'b0;
        expSetHr  = 1'b0;
        expSetMin = 1'b0;
        case (mState)
            M_RUN: if (bus.btn_mode) begin
                hrVal  = fromBcd(bus.cur_hr);
                minVal = fromBcd(bus.cur_min);
                nxt    = M_EHR;
            end
            M_EHR: begin
                if (bus.btn_cancel)    nxt = M_RUN;
                else if (bus.btn_mode) nxt = M_EMIN;
                else if (bus.btn_inc)  hrVal = (hrVal + 1) % 24;
            end
            M_EMIN: begin
                if (bus.btn_cancel)    nxt = M_RUN;
                else if (bus.btn_mode) nxt = M_LHR;
                else if (bus.btn_inc)  minVal = (minVal + 1) % 60;
            end
            M_LHR:   nxt = M_LMIN;
            default: nxt = M_RUN;
        endcase
        if (mState == M_LHR) runCount = 0;
        if ((mState == M_RUN || mState == M_LMIN) && nxt == M_RUN) begin
            runCount++;
            expTick = (runCount % CLK_DIV) == 0;
        end
        if (nxt == M_LHR) begin
            expSetHr = 1'b1;
            expNum   = toBcd(hrVal);
        end else if (nxt == M_LMIN) begin
            expSetMin = 1'b1;
            expNum    = toBcd(minVal);
        end
        wasEdit = (mState == M_EHR) || (mState == M_EMIN);
        isEdit  = (nxt == M_EHR) || (nxt == M_EMIN);
        if (isEdit) begin
            editCycles = wasEdit ? editCycles + 1 : 0;
            expBlink   = ((editCycles / BLINK_DIV) % 2) == 1;
        end else begin
            editCycles = 0;
            expBlink   = 1'b0;
        end
        expEditing = isEdit;
        mState     = nxt;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".tick"},     32'(bus.tick),     32'(expTick));
        checkOutput({tag, ".set_hr"},   32'(bus.set_hr),   32'(expSetHr));
        checkOutput({tag, ".set_min"},  32'(bus.set_min),  32'(expSetMin));
        checkOutput({tag, ".sec_clr"},  32'(bus.sec_clr),  32'(expSetMin));
        checkOutput({tag, ".set_num"},  32'({bus.set_num1, bus.set_num2}), 32'(expNum));
        checkOutput({tag, ".edit_hr"},  32'(bus.edit_hr),  32'(toBcd(hrVal)));
        checkOutput({tag, ".edit_min"}, 32'(bus.edit_min), 32'(toBcd(minVal)));
        checkOutput({tag, ".blink"},    32'(bus.blink),    32'(expBlink));
        checkOutput({tag, ".editing"},  32'(bus.editing),  32'(expEditing));
    endtask

    task automatic applyStimulus(input logic m, input logic i, input logic c);
        bus.btn_mode   = m;
        bus.btn_inc    = i;
        bus.btn_cancel = c;
        @(posedge clk);
        modelStep();
        #1;
        checkAll("step");
        bus.btn_mode   = 1'b0;
        bus.btn_inc    = 1'b0;
        bus.btn_cancel = 1'b0;
    endtask

    task automatic doReset();
        bus.btn_mode   = 1'b0;
        bus.btn_inc    = 1'b0;
        bus.btn_cancel = 1'b0;
        rst = 1'b1;
        modelReset();
        #1;
        checkAll("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Idle until tick shows; n is the number of edges taken, or -1 when the bound runs out.
    task automatic waitTick(output int n);
        n = -1;
        for (int k = 1; k <= 3 * CLK_DIV; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (bus.tick === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int ticks;
        int lastTick;
        int spacingBad;
        int n;

        bus.cur_hr  = 8'h00;
        bus.cur_min = 8'h00;
        doReset();

        // Free-running tick rate and spacing.
        ticks = 0; lastTick = -1; spacingBad = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (bus.tick === 1'b1) begin
                ticks++;
                if (lastTick >= 0 && (i - lastTick) != CLK_DIV) spacingBad++;
                lastTick = i;
            end
        end
        checkOutput("tickCount", 32'(ticks), 32'(10));
        checkOutput("tickSpacing", 32'(spacingBad), 32'(0));

        // Full edit with wraps, then the two load cycles.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h23, 8'h59, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h59, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h59, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'h01};
        bus.cur_hr  = 8'h23;
        bus.cur_min = 8'h59;
        for (int v = 0; v < 8; v++) begin
            applyStimulus(tbl[v].mode, tbl[v].inc, tbl[v].cancel);
            checkOutput("tbl.edit_hr",  32'(bus.edit_hr),  32'(tbl[v].editHr));
            checkOutput("tbl.edit_min", 32'(bus.edit_min), 32'(tbl[v].editMin));
            checkOutput("tbl.editing",  32'(bus.editing),  32'(tbl[v].editing));
            checkOutput("tbl.set_hr",   32'(bus.set_hr),   32'(tbl[v].setHr));
            checkOutput("tbl.set_min",  32'(bus.set_min),  32'(tbl[v].setMin));
            checkOutput("tbl.sec_clr",  32'(bus.sec_clr),  32'(tbl[v].setMin));
            checkOutput("tbl.set_num",  32'({bus.set_num1, bus.set_num2}), 32'(tbl[v].num));
        end
        waitTick(n);
        checkOutput("firstTickAfterLoad", 32'(n + 1), 32'(CLK_DIV));

        // Cancel with the prescaler frozen at 6.
        doReset();
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("cancel.editing", 32'(bus.editing), 32'(0));
        waitTick(n);
        checkOutput("cancel.tickDelay", 32'(n), 32'(4));

        // Simultaneous buttons.
        bus.cur_hr  = 8'h07;
        bus.cur_min = 8'h30;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("modeInc.edit_hr", 32'(bus.edit_hr), 32'(8'h07));
        checkOutput("modeInc.editing", 32'(bus.editing), 32'(1));
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("cancelMode.editing", 32'(bus.editing), 32'(0));
        checkOutput("cancelMode.set_hr", 32'(bus.set_hr), 32'(0));
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("cancelMode.set_min", 32'(bus.set_min), 32'(0));

        // Hour wrap through every value.
        bus.cur_hr = 8'h00;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("hrInc", 32'(bus.edit_hr), 32'(toBcd((i + 1) % 24)));
            checkOutput("hrValid", 32'((bus.edit_hr[3:0] <= 4'd9) && (bus.edit_hr < 8'h24)), 32'(1));
        end
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of the load.
        bus.cur_hr  = 8'h12;
        bus.cur_min = 8'h34;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("load.set_hr", 32'(bus.set_hr), 32'(1));
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("rstLoad.set_hr", 32'(bus.set_hr), 32'(0));
        checkOutput("rstLoad.editing", 32'(bus.editing), 32'(0));
        checkAll("rstLoad");
        @(posedge clk);
        #1;
        checkOutput("rstLoad.set_min", 32'(bus.set_min), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitTick(n);
        checkOutput("rstLoad.tickDelay", 32'(n), 32'(CLK_DIV));

        // Random button traffic.
        doReset();
        for (int i = 0; i < 400; i++) begin
            bus.cur_hr  = toBcd(int'($urandom_range(0, 23)));
            bus.cur_min = toBcd(int'($urandom_range(0, 59)));
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
